// File: rtl/forward_unit_pkg.sv
// Shared widths, forward-select codes and pipeline tracking entry for the forwarding unit.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package forward_unit_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int FWD_SEL_W  = 2;

    typedef logic [DATA_W-1:0]     data_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef enum logic [FWD_SEL_W-1:0] {
        FWD_SEL_NONE = 2'd0,
        FWD_SEL_MEM  = 2'd1,
        FWD_SEL_WB   = 2'd2
    } fwd_sel_e;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic      valid;
        logic      wr_en;
        reg_addr_t wr_addr;
        logic      is_load;
    } entry_t;

    localparam entry_t ENTRY_BUBBLE = '0;

    // True when the entry will write register r.
    function automatic logic entry_writes(input entry_t e, input reg_addr_t r);
        return e.valid & e.wr_en & (e.wr_addr == r);
    endfunction

endpackage

// File: rtl/forward_unit_fwd_sel.sv
// Per-operand forward source picker: newest non-load producer (MEM) beats older one (WB).
// Latency: purely combinational; the caller registers the result at pipeline advance.
// Backpressure: none; the caller decides when the result is captured.
module fwd_sel
    import forward_unit_pkg::*;
(
    input  reg_addr_t src_i,
    input  logic      use_i,
    input  entry_t    ex_e_i,
    input  entry_t    mem_e_i,
    output fwd_sel_e  sel_o
);

    // Priority pick; loads still in EX never feed MEM-forward because their data is not ready yet.
    always_comb begin
        sel_o = FWD_SEL_NONE;
        if (use_i) begin
            if (entry_writes(ex_e_i, src_i) && !ex_e_i.is_load) begin
                sel_o = FWD_SEL_MEM;
            end else if (entry_writes(mem_e_i, src_i)) begin
                sel_o = FWD_SEL_WB;
            end
        end
    end

endmodule

// File: rtl/forward_unit.sv
// Operand forwarding select for the EX ALU muxes plus one-cycle load-use stall of ID.
// Latency: select registered at advance into EX; forward data is combinational from that select.
// Backpressure: pipe_hold freezes all state; stall_id holds PC and IF/ID on a load-use hazard.
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_hold,
    input  logic             flush,
    input  logic             id_valid,
    input  logic             id_use_a,
    input  logic             id_use_b,
    input  reg_addr_t        id_src_a,
    input  reg_addr_t        id_src_b,
    input  logic             id_wr_en,
    input  reg_addr_t        id_wr_addr,
    input  logic             id_is_load,
    input  data_t            mem_result,
    input  data_t            wb_result,
    output logic             fwd_a_en,
    output logic             fwd_b_en,
    output data_t            fwd_a_data,
    output data_t            fwd_b_data,
    output logic             stall_id,
    output logic [CNT_W-1:0] lu_stall_cnt
);

    // Only the EX and MEM occupants can be forwarding sources for the next EX instruction;
    // whatever sits in WB at that point is already visible through the register file.
    entry_t           ex_q, mem_q, ex_d;
    fwd_sel_e         sel_a_q, sel_b_q, sel_a_d, sel_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             ex_load_ok;

    // Load-use hazard: a source the ID instruction reads is produced by a load still in EX.
    always_comb begin
        lu = id_valid & ex_q.is_load &
             ((id_use_a & entry_writes(ex_q, id_src_a)) |
              (id_use_b & entry_writes(ex_q, id_src_b)));
        stall_id   = lu & ~flush;
        ex_load_ok = id_valid & ~flush & ~stall_id;
    end

    // Next EX entry: real instruction when it may advance, otherwise a bubble.
    always_comb begin
        ex_d = ENTRY_BUBBLE;
        if (ex_load_ok) begin
            ex_d.valid   = 1'b1;
            ex_d.wr_en   = id_wr_en;
            ex_d.wr_addr = id_wr_addr;
            ex_d.is_load = id_is_load;
        end
    end

    // The entries about to move into MEM and WB are today's EX and MEM occupants.
    fwd_sel u_sel_a (
        .src_i   (id_src_a),
        .use_i   (id_use_a & ex_load_ok),
        .ex_e_i  (ex_q),
        .mem_e_i (mem_q),
        .sel_o   (sel_a_d)
    );

    fwd_sel u_sel_b (
        .src_i   (id_src_b),
        .use_i   (id_use_b & ex_load_ok),
        .ex_e_i  (ex_q),
        .mem_e_i (mem_q),
        .sel_o   (sel_b_d)
    );

    // Saturating count of cycles lost to load-use stalls.
    always_comb begin
        cnt_d = cnt_q;
        if (stall_id && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Pipeline tracking, selects and counter all move together on an advancing edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q    <= ENTRY_BUBBLE;
            mem_q   <= ENTRY_BUBBLE;
            sel_a_q <= FWD_SEL_NONE;
            sel_b_q <= FWD_SEL_NONE;
            cnt_q   <= '0;
        end else if (!pipe_hold) begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            cnt_q   <= cnt_d;
        end
    end

    // Forward data tracks the live stage results so late-settling values still reach the ALU.
    always_comb begin
        fwd_a_en = (sel_a_q != FWD_SEL_NONE);
        fwd_b_en = (sel_b_q != FWD_SEL_NONE);
        case (sel_a_q)
            FWD_SEL_MEM: fwd_a_data = mem_result;
            FWD_SEL_WB:  fwd_a_data = wb_result;
            default:     fwd_a_data = '0;
        endcase
        case (sel_b_q)
            FWD_SEL_MEM: fwd_b_data = mem_result;
            FWD_SEL_WB:  fwd_b_data = wb_result;
            default:     fwd_b_data = '0;
        endcase
    end

    assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_forward_unit.sv
// Directed bench for forward_unit: default-width instance plus a 2-bit-counter instance on shared stimulus.
// Latency: inputs driven at negedge, outputs checked 1 ns later or after the next posedge.
// Backpressure: pipe_hold and flush exercised directly.
module tb_forward_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_hold, flush, id_valid, id_use_a, id_use_b;
    logic [4:0]  id_src_a, id_src_b, id_wr_addr;
    logic        id_wr_en, id_is_load;
    logic [31:0] mem_result, wb_result;

    logic        fwd_a_en, fwd_b_en, stall_id;
    logic [31:0] fwd_a_data, fwd_b_data;
    logic [15:0] lu_stall_cnt;

    logic        fwd_a_en2, fwd_b_en2, stall_id2;
    logic [31:0] fwd_a_data2, fwd_b_data2;
    logic [1:0]  lu_stall_cnt2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    forward_unit #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .flush(flush),
        .id_valid(id_valid), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .mem_result(mem_result), .wb_result(wb_result),
        .fwd_a_en(fwd_a_en), .fwd_b_en(fwd_b_en),
        .fwd_a_data(fwd_a_data), .fwd_b_data(fwd_b_data),
        .stall_id(stall_id), .lu_stall_cnt(lu_stall_cnt)
    );

    forward_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .pipe_hold(pipe_hold), .flush(flush),
        .id_valid(id_valid), .id_use_a(id_use_a), .id_use_b(id_use_b),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_wr_en(id_wr_en), .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .mem_result(mem_result), .wb_result(wb_result),
        .fwd_a_en(fwd_a_en2), .fwd_b_en(fwd_b_en2),
        .fwd_a_data(fwd_a_data2), .fwd_b_data(fwd_b_data2),
        .stall_id(stall_id2), .lu_stall_cnt(lu_stall_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic id_set(input logic v, input logic ua, input logic [4:0] sa,
                          input logic ub, input logic [4:0] sb,
                          input logic we, input logic [4:0] wa, input logic ld);
        id_valid   = v;
        id_use_a   = ua;
        id_src_a   = sa;
        id_use_b   = ub;
        id_src_b   = sb;
        id_wr_en   = we;
        id_wr_addr = wa;
        id_is_load = ld;
    endtask

    task automatic id_nop();
        id_set(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    // Producer writing wa, no register reads.
    task automatic prod(input logic [4:0] wa, input logic ld);
        id_set(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, wa, ld);
    endtask

    task automatic cons_a(input logic [4:0] sa, input logic [4:0] wa);
        id_set(1'b1, 1'b1, sa, 1'b0, 5'd0, 1'b1, wa, 1'b0);
    endtask

    task automatic cons_b(input logic [4:0] sb, input logic [4:0] wa);
        id_set(1'b1, 1'b0, 5'd0, 1'b1, sb, 1'b1, wa, 1'b0);
    endtask

    task automatic drain();
        id_nop();
        repeat (3) tick();
    endtask

    initial begin
        rst        = 1'b0;
        pipe_hold  = 1'b0;
        flush      = 1'b0;
        mem_result = 32'h0;
        wb_result  = 32'h0;
        id_nop();

        // Reset state on both instances
        #2;
        chk("rst_fwd_a_en", fwd_a_en, 0);
        chk("rst_fwd_b_en", fwd_b_en, 0);
        chk("rst_fwd_a_data", fwd_a_data, 0);
        chk("rst_fwd_b_data", fwd_b_data, 0);
        chk("rst_stall", stall_id, 0);
        chk("rst_cnt", lu_stall_cnt, 0);
        chk("rst2_outs", {fwd_a_en2, fwd_b_en2, stall_id2, lu_stall_cnt2}, 0);
        chk("rst2_data", fwd_a_data2 | fwd_b_data2, 0);
        @(negedge clk);
        rst = 1'b1;

        // ALU chain, distance 1: MEM-forward on A
        prod(5'd1, 1'b0);
        tick();
        cons_a(5'd1, 5'd5);
        #1 chk("alu_no_stall", stall_id, 0);
        tick();
        mem_result = 32'h1234;
        #1;
        chk("alu_fwd_a_en", fwd_a_en, 1);
        chk("alu_fwd_a_data", fwd_a_data, 32'h1234);
        chk("alu_fwd_b_en", fwd_b_en, 0);

        // Distance 2: WB-forward on B
        drain();
        prod(5'd2, 1'b0);
        tick();
        id_set(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        tick();
        cons_b(5'd2, 5'd9);
        tick();
        wb_result = 32'hBEEF;
        #1;
        chk("d2_fwd_b_en", fwd_b_en, 1);
        chk("d2_fwd_b_data", fwd_b_data, 32'hBEEF);
        chk("d2_fwd_a_en", fwd_a_en, 0);

        // Distance 3: register file, no forward
        drain();
        prod(5'd2, 1'b0);
        tick();
        id_set(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        tick();
        id_set(1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b1, 5'd11, 1'b0);
        tick();
        cons_b(5'd2, 5'd9);
        tick();
        #1;
        chk("d3_fwd_b_en", fwd_b_en, 0);
        chk("d3_fwd_b_data", fwd_b_data, 0);

        // Load-use: one stall, bubble, then WB-forward
        drain();
        prod(5'd3, 1'b1);
        tick();
        cons_a(5'd3, 5'd6);
        #1;
        chk("lu_stall_on", stall_id, 1);
        chk("lu_cnt_before", lu_stall_cnt, 0);
        tick();
        #1;
        chk("lu_stall_off", stall_id, 0);
        chk("lu_cnt_after", lu_stall_cnt, 1);
        chk("lu_cnt2_after", lu_stall_cnt2, 1);
        chk("lu_bubble_fwd_a", fwd_a_en, 0);
        tick();
        wb_result = 32'h00A5;
        #1;
        chk("lu_fwd_a_en", fwd_a_en, 1);
        chk("lu_fwd_a_data", fwd_a_data, 32'h00A5);

        // Double producer: MEM beats WB
        drain();
        prod(5'd4, 1'b0);
        tick();
        prod(5'd4, 1'b0);
        tick();
        cons_a(5'd4, 5'd10);
        tick();
        mem_result = 32'h1111;
        wb_result  = 32'h2222;
        #1;
        chk("dbl_fwd_a_en", fwd_a_en, 1);
        chk("dbl_fwd_a_data", fwd_a_data, 32'h1111);

        // Flush concurrent with load-use: no stall, bubble, counter unchanged
        drain();
        prod(5'd3, 1'b1);
        tick();
        cons_a(5'd3, 5'd6);
        flush = 1'b1;
        #1 chk("flush_no_stall", stall_id, 0);
        tick();
        flush = 1'b0;
        cons_b(5'd6, 5'd12);
        #1;
        chk("flush_stall_next", stall_id, 0);
        chk("flush_cnt", lu_stall_cnt, 1);
        tick();
        #1 chk("flush_bubble_fwd_b", fwd_b_en, 0);

        // Hold for 3 cycles freezes select; data still follows live result
        drain();
        prod(5'd1, 1'b0);
        tick();
        cons_a(5'd1, 5'd5);
        tick();
        mem_result = 32'h1234;
        #1 chk("hold_pre_en", fwd_a_en, 1);
        pipe_hold = 1'b1;
        id_nop();
        for (int i = 0; i < 3; i++) begin
            tick();
            mem_result = 32'h5000 + i;
            #1;
            chk("hold_fwd_a_en", fwd_a_en, 1);
            chk("hold_fwd_a_data", fwd_a_data, 32'h5000 + i);
        end
        pipe_hold = 1'b0;
        tick();
        #1 chk("hold_release_en", fwd_a_en, 0);

        // Hold during a stall: stall persists, no counting, resumes cleanly
        drain();
        prod(5'd3, 1'b1);
        tick();
        cons_a(5'd3, 5'd6);
        pipe_hold = 1'b1;
        tick();
        tick();
        #1;
        chk("hstall_stall", stall_id, 1);
        chk("hstall_cnt_frozen", lu_stall_cnt, 1);
        pipe_hold = 1'b0;
        tick();
        #1;
        chk("hstall_stall_off", stall_id, 0);
        chk("hstall_cnt", lu_stall_cnt, 2);
        chk("hstall_cnt2", lu_stall_cnt2, 2);
        tick();
        wb_result = 32'h77;
        #1;
        chk("hstall_fwd_a_en", fwd_a_en, 1);
        chk("hstall_fwd_a_data", fwd_a_data, 32'h77);

        // Async reset in the middle of a stall, well before the next posedge
        prod(5'd3, 1'b1);
        tick();
        cons_a(5'd3, 5'd6);
        #1 chk("arst_pre_stall", stall_id, 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_stall", stall_id, 0);
        chk("arst_cnt", lu_stall_cnt, 0);
        chk("arst_en", {fwd_a_en, fwd_b_en}, 0);
        chk("arst_data", fwd_a_data | fwd_b_data, 0);
        id_nop();
        @(negedge clk);
        rst = 1'b1;

        // Counter saturation: 2-bit instance sticks at 3, 16-bit one keeps counting
        for (int i = 0; i < 4; i++) begin
            prod(5'd3, 1'b1);
            tick();
            cons_a(5'd3, 5'd6);
            tick();
            id_nop();
            tick();
            tick();
            if (i == 2) begin
                chk("sat_cnt2_at3", lu_stall_cnt2, 3);
                chk("sat_cnt_at3", lu_stall_cnt, 3);
            end
        end
        chk("sat_cnt2_held", lu_stall_cnt2, 3);
        chk("sat_cnt_4", lu_stall_cnt, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/forward_unit.md
# forward_unit

Operand-forwarding and load-use hazard controller for the 4-stage-visible ID/EX/MEM/WB pipeline. It tracks in-flight register writes, and drives the forward-enable/forward-data pair consumed by the EX-stage ALU operand A and B muxes. It also raises a one-cycle ID stall on load-use hazards. It is the producing end of the `*_FOWD_en` / `data_FOWD` interface.

## Interface
- `CNT_W`, default 16: width of the load-use stall event counter.
- `clk` in 1: pipeline clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low. This polarity and synchronicity are fixed.
- `pipe_hold` in 1: global freeze (structural stall). All tracking state holds.
- `flush` in 1: kills the instruction in ID. A bubble enters EX on the next advance.
- `id_valid` in 1: ID holds a real instruction.
- `id_use_a`, `id_use_b` in 1: the ID instruction reads operand A / B from the register file.
- `id_src_a`, `id_src_b` in `REG_ADDR_BUS`: source register addresses.
- `id_wr_en` in 1, `id_wr_addr` in `REG_ADDR_BUS`: the ID instruction writes this register.
- `id_is_load` in 1: the ID instruction is a memory load.
- `mem_result` in `DATA_BUS`: EX/MEM-latched ALU result of the instruction now in MEM.
- `wb_result` in `DATA_BUS`: final write-back value of the instruction now in WB.
- `fwd_a_en`, `fwd_b_en` out 1: forward enable to the ALU A / B muxes. Registered.
- `fwd_a_data`, `fwd_b_data` out `DATA_BUS`: forward data. Combinational from the registered select.
- `stall_id` out 1: hold PC and IF/ID. Combinational.
- `lu_stall_cnt` out `CNT_W`: count of load-use stall cycles, saturating.

## Operation
- Tracking entries `ex_e`, `mem_e`, `wb_e`. Each entry is {valid, wr_en, wr_addr, is_load}.
- An entry "writes r" when valid & wr_en & wr_addr==r.
- Hazard in ID: `lu = id_valid & ex_e writes src & ex_e.is_load`, checked for each used source (A or B).
- `stall_id = lu & ~flush`. A flushed instruction never stalls.
- Advance, on a clock edge with `pipe_hold`=0:
  - `wb_e <= mem_e`, `mem_e <= ex_e`.
  - `ex_e` loads the ID fields. It loads a bubble (valid=0) instead when `flush`, `stall_id` or `~id_valid`.
- Forward select per operand, computed at advance from the entries moving into MEM/WB:
  - MEM-select if `ex_e` writes src and is not a load. This is the newest producer and has priority.
  - Otherwise WB-select if `mem_e` writes src.
  - Otherwise none.
  - Select is none whenever the operand is unused or the new EX entry is a bubble.
  - A load in `ex_e` never gives MEM-select. `stall_id` guarantees the consumer meets it in WB.
- `fwd_x_en` = (select != none). `fwd_x_data` = `mem_result` for MEM-select, `wb_result` for WB-select, 0 for none.
- `lu_stall_cnt` increments on each advancing edge where `stall_id`=1. It saturates at all-ones.
- On `pipe_hold`=1: entries, selects and the counter hold. `stall_id` is still evaluated, so the outputs stay coherent.

## Timing
- Reset (async, `rst`=0):
  - All entries invalid, selects none, counter 0.
  - Outputs: `fwd_a_en`=`fwd_b_en`=0, `fwd_*_data`=0, `stall_id`=0, `lu_stall_cnt`=0.
- Forwarding latency: the select is valid from the first EX cycle of the consumer, one edge after ID. It is stable for the whole EX cycle.
- Forward data follows `mem_result`/`wb_result` within the same cycle, with no extra register.
- Producer distance 1 (ALU): MEM-forward. Distance 2: WB-forward. Distance ≥3: register file, no forward.
- Load followed by a dependent instruction: exactly 1 stall cycle, then WB-forward.
- Simultaneous events:
  - `pipe_hold` beats `flush`, which beats load-use.
  - Flush and lu together: bubble, no stall, no count.
  - Hold released mid-stall: resumes with the same entries.
- Reset asserted mid-stall clears the stall immediately and asynchronously.

## Structure
- Shared `define.v` holds:
  - the existing `DATA_BUS` and `REG_ADDR_BUS`;
  - new `FWD_SEL_BUS` (2 bits);
  - new `FWD_SEL_NONE`/`FWD_SEL_MEM`/`FWD_SEL_WB` codes.
- One sub-module, `fwd_sel`, instantiated twice (A and B). It is combinational. Inputs: src, use, `ex_e`, `mem_e`. Output: select code.

## Test plan
- ALU chain: `ADDU R1←…` then `ADDU …←R1` back-to-back, `mem_result`=0x1234. In the consumer EX cycle, `fwd_a_en`=1 and `fwd_a_data`=0x1234.
- Distance 2: producer writes R2, one unrelated instruction, then a consumer of R2 on B, `wb_result`=0xBEEF. Expect `fwd_b_en`=1 and `fwd_b_data`=0xBEEF. At distance 3, `fwd_b_en`=0.
- Load-use: `LW R3` then a consumer of R3.
  - `stall_id`=1 for exactly 1 cycle; bubble in EX; `lu_stall_cnt` 0→1.
  - Next cycle, WB-forward of `wb_result`=0x00A5.
- Double producer: R4 written at distance 1 and distance 2, `mem_result`=0x1111, `wb_result`=0x2222. Expect `fwd_a_data`=0x1111 (MEM priority).
- Events:
  - Flush concurrent with load-use: `stall_id`=0, EX bubble, counter unchanged.
  - `pipe_hold`=1 for 3 cycles: the select and `fwd_*_en` are frozen.
- Async reset pulse during a stall: all outputs 0 without waiting for `clk`. Counter saturation with `CNT_W`=2 stays at 3.
